// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter with registered one-hot grant and a
// bounded tenure under contention; preempt pulses when tenure expiry moves the grant.
module rr_arbiter_2 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] request,
    output logic [1:0] grant,
    output logic       preempt
);

    localparam int CNT_W     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int HOLD_LAST = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_hold_cnt;
    logic               r_last;
    logic [1:0]         r_grant;
    logic               r_preempt;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_hold_nxt;
    logic               w_last_nxt;
    logic               w_preempt_nxt;
    logic [1:0]         w_grant_nxt;
    logic               w_own;
    logic               w_req_own;
    logic               w_req_oth;
    logic               w_expire;

    function automatic logic [1:0] decode_grant(input state_t st);
        case (st)
            ST_OWN0: decode_grant = 2'b01;
            ST_OWN1: decode_grant = 2'b10;
            default: decode_grant = 2'b00;
        endcase
    endfunction

    assign w_own     = (r_state == ST_OWN1);
    assign w_req_own = w_own ? request[1] : request[0];
    assign w_req_oth = w_own ? request[0] : request[1];
    // MAX_HOLD of zero disables preemption entirely.
    assign w_expire  = (MAX_HOLD != 0) && (r_hold_cnt == CNT_W'(HOLD_LAST));

    // State register: owner, tenure counter, rotation pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_last     <= 1'b1;
            r_grant    <= 2'b00;
            r_preempt  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_last     <= w_last_nxt;
            r_grant    <= w_grant_nxt;
            r_preempt  <= w_preempt_nxt;
        end
    end

    // Next-state logic: pick, keep, release or preempt the owner.
    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = '0;
        w_last_nxt    = r_last;
        w_preempt_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                case (request)
                    2'b01:   w_state_nxt = ST_OWN0;
                    2'b10:   w_state_nxt = ST_OWN1;
                    2'b11:   w_state_nxt = r_last ? ST_OWN0 : ST_OWN1;
                    default: w_state_nxt = ST_IDLE;
                endcase
            end
            ST_OWN0, ST_OWN1: begin
                if (!w_req_own) begin
                    // Hand straight to a waiting requester so there is no idle gap.
                    w_last_nxt  = w_own;
                    if (w_req_oth) begin
                        w_state_nxt = w_own ? ST_OWN0 : ST_OWN1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (!w_req_oth) begin
                    w_hold_nxt = '0;
                end else if (w_expire) begin
                    w_state_nxt   = w_own ? ST_OWN0 : ST_OWN1;
                    w_last_nxt    = w_own;
                    w_preempt_nxt = 1'b1;
                end else if (MAX_HOLD != 0) begin
                    w_hold_nxt = r_hold_cnt + CNT_W'(1);
                end else begin
                    w_hold_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode: grant follows the next state so it is registered with it.
    always_comb begin
        w_grant_nxt = decode_grant(w_state_nxt);
    end

    assign grant   = r_grant;
    assign preempt = r_preempt;

endmodule

// File: tb/tb_rr_arbiter_2.sv
// Randomised and directed stimulus for rr_arbiter_2, checked every cycle
// against a turn-taking reference model of the arbitration rules.
module tb_rr_arbiter_2;

    localparam int MH = 8;

    logic       clk;
    logic       rst;
    logic [1:0] request;
    logic [1:0] grant;
    logic       preempt;

    int checks;
    int failures;

    // Reference model: who owns the resource, who was served last, and how
    // many contested cycles the current owner has used.
    int         m_owner;
    int         m_last;
    int         m_used;
    logic [1:0] exp_grant;
    logic       exp_preempt;

    rr_arbiter_2 #(.MAX_HOLD(MH)) dut (
        .clk     (clk),
        .rst     (rst),
        .request (request),
        .grant   (grant),
        .preempt (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic [1:0] req);
        int other;
        exp_preempt = 1'b0;
        if (r) begin
            m_owner = -1;
            m_last  = 1;
            m_used  = 0;
        end else if (m_owner < 0) begin
            m_used = 0;
            if (req == 2'b11)   m_owner = 1 - m_last;
            else if (req[0])    m_owner = 0;
            else if (req[1])    m_owner = 1;
            else                m_owner = -1;
        end else begin
            other = 1 - m_owner;
            if (!req[m_owner]) begin
                m_last  = m_owner;
                m_owner = req[other] ? other : -1;
                m_used  = 0;
            end else if (req[other]) begin
                m_used = m_used + 1;
                if (MH > 0 && m_used == MH) begin
                    m_last      = m_owner;
                    m_owner     = other;
                    m_used      = 0;
                    exp_preempt = 1'b1;
                end
            end else begin
                m_used = 0;
            end
        end
        if (m_owner == 0)      exp_grant = 2'b01;
        else if (m_owner == 1) exp_grant = 2'b10;
        else                   exp_grant = 2'b00;
    endtask

    task automatic step(input logic r, input logic [1:0] req);
        rst     = r;
        request = req;
        @(posedge clk);
        model_update(r, req);
        #1;
        check_val("grant", grant, exp_grant);
        check_val("preempt", {1'b0, preempt}, {1'b0, exp_preempt});
        if (grant == 2'b11) begin
            check_val("grant_onehot", grant, 2'b00);
        end
    endtask

    initial begin
        logic [1:0] rq;
        logic       rr;
        int         sw;
        checks   = 0;
        failures = 0;
        m_owner  = -1;
        m_last   = 1;
        m_used   = 0;
        rst      = 1'b1;
        request  = 2'b11;

        // Reset held with contention, then requester 0 wins first.
        step(1'b1, 2'b11);
        step(1'b1, 2'b11);
        check_val("reset_grant", grant, 2'b00);
        step(1'b0, 2'b11);
        check_val("first_after_reset", grant, 2'b01);

        // Single requester 1 for 20 cycles.
        step(1'b1, 2'b00);
        for (int i = 0; i < 20; i++) step(1'b0, 2'b10);
        check_val("solo_owner1", grant, 2'b10);

        // Continuous contention: 8-cycle tenures and preempt at each switch.
        step(1'b1, 2'b00);
        sw = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 2'b11);
            if (preempt) sw++;
        end
        check_val("preempt_count", sw[1:0], 2'd1 + 2'd3);

        // Owner 0 releases under contention: direct handover without gap.
        step(1'b1, 2'b00);
        step(1'b0, 2'b01);
        step(1'b0, 2'b11);
        step(1'b0, 2'b10);
        check_val("handover", grant, 2'b10);

        // Owner 1 releases to idle, then contention favours requester 0.
        step(1'b0, 2'b00);
        step(1'b0, 2'b11);
        check_val("rotate_after_idle", grant, 2'b01);

        // Reset during owner-1 tenure, then a full fresh tenure.
        step(1'b1, 2'b00);
        step(1'b0, 2'b10);
        for (int i = 0; i < 5; i++) step(1'b0, 2'b11);
        step(1'b1, 2'b11);
        check_val("reset_mid_tenure", grant, 2'b00);
        for (int i = 0; i < 20; i++) step(1'b0, 2'b11);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rr = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) rq = 2'($urandom_range(0, 3));
            else                           rq = request;
            step(rr, rq);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
